// File: rtl/timer_device.sv
// Memory-mapped countdown timer (one-shot / periodic) feeding one CP0 HWInt line.
// CTRL at word 0, PRESET at word 1, COUNT (read-only) at word 2.
module timer_device (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic enable, periodic, wr_ctrl, wr_preset, flag_set;
  logic unused_addr;

  assign enable      = ctrl_q[0];
  assign periodic    = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl     = we && (addr[3:2] == 2'd0);
  assign wr_preset   = we && (addr[3:2] == 2'd1);
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    flag_set   = 1'b0;

    unique case (state_q)
      IDLE: if (enable) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d  = 32'd0;
          flag_set = 1'b1;
          state_d  = INT;
        end
      end
      INT: begin
        state_d = IDLE;
        if (periodic) irq_flag_d = 1'b0;
        else          ctrl_d[0]  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Bus writes are applied after the FSM so a CTRL write wins over the Enable clear,
    // and a flag set is applied last so a same-edge clear never loses an interrupt.
    if (wr_ctrl)   ctrl_d   = wdata[3:0];
    if (wr_preset) preset_d = wdata;
    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;
    if (flag_set)             irq_flag_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    unique case (addr[3:2])
      2'd0:    rdata = {28'd0, ctrl_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[3];

endmodule
